// File: rtl/mipos_loader_pkg.sv
// Shared constants for the program-memory loader: FSM state codes, the default
// frame marker and the sticky error codes reported to software.
package mipos_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_HDR  = 3'd1;
    localparam state_t S_DATA = 3'd2;
    localparam state_t S_WR   = 3'd3;
    localparam state_t S_CHK  = 3'd4;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_ADDR  = 2'd3;

endpackage

// File: rtl/mipos_loader_word_packer.sv
// Packs a byte stream into 32-bit little-endian words. The word is presented
// combinationally together with the 4th byte so the caller can register it on
// the same edge that accepts that byte.
module mipos_loader_word_packer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // Shift earlier bytes down so byte 0 ends up in the least significant lane
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/mipos_soc_mem_loader.sv
// Framed byte-stream loader for the on-chip program memory. Parses one load
// command, writes packed words through the memory s1 port and holds the CPU in
// reset while a load is in progress.
module mipos_soc_mem_loader
    import mipos_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MEM_DEPTH = 2560,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [3:0]        o_mem_byteen,
    output logic              o_mem_cs,
    output logic              o_mem_write,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_clken,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_err_code
);

    state_t            r_state, w_state_nx;
    logic [1:0]        r_hdr_idx, w_hdr_idx_nx;
    logic [7:0]        r_addr_lo, w_addr_lo_nx;
    logic [7:0]        r_addr_hi, w_addr_hi_nx;
    logic [7:0]        r_cnt_lo, w_cnt_lo_nx;
    logic [15:0]       r_words_left, w_words_nx;
    logic [7:0]        r_csum, w_csum_nx;
    logic              r_in_ready;
    logic [ADDR_W-1:0] r_mem_address, w_addr_nx;
    logic [31:0]       r_mem_wdata, w_wdata_nx;
    logic              r_mem_write, w_write_nx;
    logic              r_cpu_hold, w_hold_nx;
    logic              r_busy;
    logic              r_done, w_done_nx;
    logic [1:0]        r_err_code, w_err_nx;

    logic              w_accept;
    logic              w_pk_clear, w_pk_valid, w_pk_word_valid;
    logic [31:0]       w_pk_word;
    logic [15:0]       w_start16, w_count;
    logic [16:0]       w_end;
    logic              w_addr_bad, w_range_bad;

    assign w_accept  = i_in_valid && r_in_ready;
    assign w_start16 = {r_addr_hi, r_addr_lo};
    assign w_count   = {i_in_data, r_cnt_lo};
    // 17-bit sum so a huge count cannot wrap back into the legal range
    assign w_end       = 17'(w_start16[ADDR_W-1:0]) + 17'(w_count);
    assign w_addr_bad  = (w_start16 >> ADDR_W) != 16'd0;
    assign w_range_bad = w_end > 17'(MEM_DEPTH);

    mipos_loader_word_packer u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_pk_clear),
        .i_valid      (w_pk_valid),
        .i_byte       (i_in_data),
        .o_word       (w_pk_word),
        .o_word_valid (w_pk_word_valid)
    );

    // Next-state and datapath decode for the load FSM
    always_comb begin
        w_state_nx   = r_state;
        w_hdr_idx_nx = r_hdr_idx;
        w_addr_lo_nx = r_addr_lo;
        w_addr_hi_nx = r_addr_hi;
        w_cnt_lo_nx  = r_cnt_lo;
        w_words_nx   = r_words_left;
        w_csum_nx    = r_csum;
        w_addr_nx    = r_mem_address;
        w_wdata_nx   = r_mem_wdata;
        w_write_nx   = 1'b0;
        w_hold_nx    = r_cpu_hold;
        w_done_nx    = r_done;
        w_err_nx     = r_err_code;
        w_pk_clear   = 1'b0;
        w_pk_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pk_clear = 1'b1;
                if (w_accept && (i_in_data == SYNC_BYTE)) begin
                    w_state_nx   = S_HDR;
                    w_hdr_idx_nx = 2'd0;
                    w_csum_nx    = 8'd0;
                    w_done_nx    = 1'b0;
                    w_err_nx     = ERR_NONE;
                end
            end
            S_HDR: begin
                if (w_accept) begin
                    w_hdr_idx_nx = r_hdr_idx + 2'd1;
                    case (r_hdr_idx)
                        2'd0:    w_addr_lo_nx = i_in_data;
                        2'd1:    w_addr_hi_nx = i_in_data;
                        2'd2:    w_cnt_lo_nx  = i_in_data;
                        default: begin
                            if (w_addr_bad) begin
                                w_err_nx   = ERR_ADDR;
                                w_state_nx = S_IDLE;
                            end else if (w_range_bad) begin
                                w_err_nx   = ERR_RANGE;
                                w_state_nx = S_IDLE;
                            end else begin
                                w_hold_nx  = 1'b1;
                                w_addr_nx  = w_start16[ADDR_W-1:0];
                                w_words_nx = w_count;
                                w_state_nx = (w_count == 16'd0) ? S_CHK : S_DATA;
                            end
                        end
                    endcase
                end
            end
            S_DATA: begin
                w_pk_valid = w_accept;
                if (w_accept) begin
                    w_csum_nx = r_csum ^ i_in_data;
                end
                if (w_pk_word_valid) begin
                    w_state_nx = S_WR;
                    w_write_nx = 1'b1;
                    w_wdata_nx = w_pk_word;
                end
            end
            S_WR: begin
                // The strobe is already on the bus this cycle; advance past it
                w_addr_nx  = r_mem_address + ADDR_W'(1);
                w_words_nx = r_words_left - 16'd1;
                w_state_nx = (r_words_left == 16'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (w_accept) begin
                    if (i_in_data == r_csum) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_err_nx = ERR_CSUM;
                    end
                    w_hold_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_hold_nx  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial frame
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_hdr_idx     <= '0;
            r_addr_lo     <= '0;
            r_addr_hi     <= '0;
            r_cnt_lo      <= '0;
            r_words_left  <= '0;
            r_csum        <= '0;
            r_in_ready    <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_write   <= 1'b0;
            r_cpu_hold    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_state       <= w_state_nx;
            r_hdr_idx     <= w_hdr_idx_nx;
            r_addr_lo     <= w_addr_lo_nx;
            r_addr_hi     <= w_addr_hi_nx;
            r_cnt_lo      <= w_cnt_lo_nx;
            r_words_left  <= w_words_nx;
            r_csum        <= w_csum_nx;
            r_in_ready    <= (w_state_nx != S_WR);
            r_mem_address <= w_addr_nx;
            r_mem_wdata   <= w_wdata_nx;
            r_mem_write   <= w_write_nx;
            r_cpu_hold    <= w_hold_nx;
            r_busy        <= (w_state_nx != S_IDLE);
            r_done        <= w_done_nx;
            r_err_code    <= w_err_nx;
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_mem_address = r_mem_address;
    assign o_mem_byteen  = 4'hF;
    assign o_mem_cs      = r_mem_write;
    assign o_mem_write   = r_mem_write;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_clken   = 1'b1;
    assign o_cpu_hold    = r_cpu_hold;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_mipos_soc_mem_loader.sv
// Bench for the program-memory loader: directed frames plus randomized frames,
// each checked against a frame-level model of the expected writes and status.
module tb_mipos_soc_mem_loader;

    localparam int DEPTH = 2560;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteen;
    logic        mem_cs;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        mem_clken;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int n_total = 0;
    int n_pass  = 0;
    int bad_ready = 0;
    int bad_cs    = 0;

    logic [43:0] wr_q[$];
    logic [7:0]  pl[$];

    always #5 clk = ~clk;

    mipos_soc_mem_loader dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_in_valid    (in_valid),
        .i_in_data     (in_data),
        .o_in_ready    (in_ready),
        .o_mem_address (mem_address),
        .o_mem_byteen  (mem_byteen),
        .o_mem_cs      (mem_cs),
        .o_mem_write   (mem_write),
        .o_mem_wdata   (mem_wdata),
        .o_mem_clken   (mem_clken),
        .o_cpu_hold    (cpu_hold),
        .o_busy        (busy),
        .o_done        (done),
        .o_err_code    (err_code)
    );

    // Log every write and watch handshake invariants between clock edges
    always @(negedge clk) begin
        if (mem_write === 1'b1) wr_q.push_back({mem_address, mem_wdata});
        if (mem_cs !== mem_write) bad_cs++;
        if (busy === 1'b1 && in_ready === mem_write) bad_ready++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_total++;
            $error("FAIL ready_timeout: observed in_ready=%b expected 1 within 20 cycles", in_ready);
        end
        @(negedge clk);
    endtask

    // Sends one frame whose payload is in pl and checks it against the model
    task automatic run_frame(input string tag, input logic [15:0] start, input logic [15:0] cnt,
                             input bit force_cs, input logic [7:0] cs_val);
        logic [7:0]  x = 8'd0;
        logic [7:0]  cs;
        logic [31:0] w;
        int          exp_err;
        foreach (pl[i]) x ^= pl[i];
        cs = force_cs ? cs_val : x;
        if (start >= 16'd4096) exp_err = 3;
        else if (int'(start) + int'(cnt) > DEPTH) exp_err = 1;
        else exp_err = 0;
        wr_q.delete();
        send_byte(8'hA5);
        send_byte(start[7:0]);
        send_byte(start[15:8]);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        if (exp_err != 0) begin
            in_valid = 1'b0;
            @(negedge clk);
            check({tag, "/err"}, 64'(err_code), 64'(exp_err));
            check({tag, "/err_busy"}, 64'(busy), 64'd0);
            check({tag, "/err_hold"}, 64'(cpu_hold), 64'd0);
            check({tag, "/err_done"}, 64'(done), 64'd0);
            check({tag, "/err_nowr"}, 64'(wr_q.size()), 64'd0);
            return;
        end
        check({tag, "/hold"}, 64'(cpu_hold), 64'd1);
        for (int i = 0; i < int'(cnt); i++) begin
            for (int k = 0; k < 4; k++) send_byte(pl[4*i+k]);
            w = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
            check({tag, "/wr_lat"}, 64'(mem_write), 64'd1);
            check({tag, "/wr_lat_data"}, 64'(mem_wdata), 64'(w));
        end
        send_byte(cs);
        in_valid = 1'b0;
        check({tag, "/done"}, 64'(done), 64'(cs == x));
        check({tag, "/err"}, 64'(err_code), (cs == x) ? 64'd0 : 64'd2);
        check({tag, "/hold_end"}, 64'(cpu_hold), 64'd0);
        check({tag, "/busy_end"}, 64'(busy), 64'd0);
        check({tag, "/nwr"}, 64'(wr_q.size()), 64'(cnt));
        for (int i = 0; i < wr_q.size() && i < int'(cnt); i++) begin
            w = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
            check({tag, "/wr"}, 64'(wr_q[i]), 64'({12'(int'(start) + i), w}));
        end
    endtask

    int          c, m;
    logic [15:0] s;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_write", 64'(mem_write), 64'd0);
        check("rst_cs", 64'(mem_cs), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_code), 64'd0);
        check("byteen", 64'(mem_byteen), 64'hF);
        check("clken", 64'(mem_clken), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);

        // Basic two-word frame with correct checksum
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame("t1", 16'h0010, 16'd2, 1'b1, 8'h88);

        // Header errors: range, address high bits, count too large to wrap
        pl.delete();
        run_frame("t2_range", 16'h09FF, 16'd2, 1'b0, 8'h00);
        run_frame("t2_addr", 16'h1000, 16'd1, 1'b0, 8'h00);
        run_frame("t2_wide", 16'h09FF, 16'hFFFF, 1'b0, 8'h00);

        // Bad checksum keeps the written data
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame("t3", 16'h0010, 16'd2, 1'b1, 8'h00);

        // Junk before SYNC, then an empty frame
        send_byte(8'h00);
        send_byte(8'hFF);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_junk_idle", 64'(busy), 64'd0);
        pl.delete();
        run_frame("t4", 16'h0000, 16'd0, 1'b0, 8'h00);

        // Reset after the 3rd data byte discards the partial frame
        wr_q.delete();
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("t5_rst_write", 64'(mem_write), 64'd0);
        check("t5_rst_hold", 64'(cpu_hold), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_no_write", 64'(wr_q.size()), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame("t5_resend", 16'h0010, 16'd2, 1'b0, 8'h00);

        // Last two legal words with in_valid held high through the payload
        pl.delete();
        repeat (8) pl.push_back(8'($urandom));
        run_frame("t6", 16'h09FE, 16'd2, 1'b0, 8'h00);
        if (wr_q.size() > 0) check("t6_last_addr", 64'(wr_q[$][43:32]), 64'h9FF);
        else check("t6_last_addr", 64'(wr_q.size()), 64'd2);

        // Randomized frames around the boundaries
        for (int t = 0; t < 10; t++) begin
            c = int'($urandom_range(0, 4));
            m = int'($urandom_range(0, 3));
            case (m)
                0:       s = 16'(DEPTH - c);
                1:       s = 16'(DEPTH - c + 1);
                2:       s = 16'($urandom_range(4096, 65535));
                default: s = 16'($urandom_range(0, 2000));
            endcase
            pl.delete();
            repeat (4 * c) pl.push_back(8'($urandom));
            run_frame("rand", s, 16'(c), $urandom_range(0, 1) == 1, 8'($urandom));
        end

        check("ready_low_only_in_wr", 64'(bad_ready), 64'd0);
        check("cs_tracks_write", 64'(bad_cs), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
